decode_issue_stage: RTL and testbench

//  Parametrised successor to the single-shot decoder. Registered decode/operand-fetch stage

---
 rtl/decode_issue_stage.sv | 111 +++++++++++
 tb/tb_decode_issue_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: registered RV32I decode/operand-fetch stage with writeback bypass and register scoreboard
module decode_issue_stage #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS = 1,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    instr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  regs,
  input  logic                           wb_valid,
  input  logic [RW-1:0]                  wb_rd,
  input  logic [XLEN-1:0]                wb_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [8:0]                     out_op,
  output logic [XLEN-1:0]                op1,
  output logic [XLEN-1:0]                op2,
  output logic [XLEN-1:0]                op3,
  output logic [RW-1:0]                  rd,
  output logic [NUM_REGS-1:0]            busy
);
  localparam logic [8:0] NO_OP = 9'h000;
  logic [6:0] opc;
  logic [8:0] dec_op;
  logic is_r, is_i, is_si, is_s, is_b, is_j, is_u, use1, use2, byp1, byp2, hz1, hz2, fire;
  logic [RW-1:0] rs1, rs2, dec_rd;
  logic [31:0] imm;
  logic [XLEN-1:0] src1, src2, dec_op1, dec_op2, dec_op3;
  logic out_valid_d, out_valid_q;
  logic [8:0] out_op_d, out_op_q;
  logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q, op3_d, op3_q;
  logic [RW-1:0] rd_d, rd_q;
  logic [NUM_REGS-1:0] busy_d, busy_q;
  always_comb begin
    opc = instr[6:0];
    // one-hot class: {AUIPC, LUI, JAL, BRANCH, STORE, JALR, LOAD, OP-IMM, OP}; unknown opcodes give NO_OP
    dec_op = {opc == 7'h17, opc == 7'h37, opc == 7'h6f, opc == 7'h63, opc == 7'h23,
              opc == 7'h67, opc == 7'h03, opc == 7'h13, opc == 7'h33};
    is_r = dec_op[0];
    is_i = |dec_op[3:1];
    is_si = dec_op[1] && instr[13:12] == 2'b01;
    is_s = dec_op[4];
    is_b = dec_op[5];
    is_j = dec_op[6];
    is_u = |dec_op[8:7];
    use1 = is_r || is_i || is_s || is_b;
    use2 = is_r || is_s || is_b;
    rs1 = instr[15 +: RW];
    rs2 = instr[20 +: RW];
    dec_rd = (is_r || is_i || is_j || is_u) ? instr[7 +: RW] : '0;
    imm = is_si ? {27'b0, instr[24:20]} :
          is_i  ? {{20{instr[31]}}, instr[31:20]} :
          is_s  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          is_b  ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          is_j  ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          is_u  ? {instr[31:12], 12'b0} : 32'b0;
    byp1 = BYPASS != 0 && wb_valid && wb_rd == rs1;
    byp2 = BYPASS != 0 && wb_valid && wb_rd == rs2;
    src1 = rs1 == '0 ? '0 : byp1 ? wb_data : regs[rs1];
    src2 = rs2 == '0 ? '0 : byp2 ? wb_data : regs[rs2];
    hz1 = use1 && rs1 != '0 && busy_q[rs1] && !byp1;
    hz2 = use2 && rs2 != '0 && busy_q[rs2] && !byp2;
    dec_op1 = use1 ? src1 : (is_j || is_u) ? XLEN'(imm) : '0;
    dec_op2 = use2 ? src2 : is_i ? XLEN'(imm) : '0;
    dec_op3 = (is_s || is_b) ? XLEN'(imm) : '0;
    in_ready = !(hz1 || hz2) && (!out_valid_q || out_ready) && !flush;
    fire = in_valid && in_ready;
    out_valid_d = !flush && (fire || (out_valid_q && !out_ready));
    out_op_d = fire ? dec_op : out_op_q;
    op1_d = fire ? dec_op1 : op1_q;
    op2_d = fire ? dec_op2 : op2_q;
    op3_d = fire ? dec_op3 : op3_q;
    rd_d = fire ? dec_rd : rd_q;
    // clears first so a same-edge set by a new producer wins
    busy_d = busy_q;
    if (flush && out_valid_q) busy_d[rd_q] = 1'b0;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (fire) busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op_q <= NO_OP;
      op1_q <= '0;
      op2_q <= '0;
      op3_q <= '0;
      rd_q <= '0;
      busy_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q <= out_op_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      op3_q <= op3_d;
      rd_q <= rd_d;
      busy_q <= busy_d;
    end
  assign out_valid = out_valid_q;
  assign out_op = out_op_q;
  assign op1 = op1_q;
  assign op2 = op2_q;
  assign op3 = op3_q;
  assign rd = rd_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed scenarios plus randomized traffic against a format-level reference model
module tb_decode_issue_stage;
  logic clk = 1'b0;
  logic rst, iv1, iv0, ir1, ir0, wb_valid, flush, out_ready, ov1, ov0;
  logic [31:0] instr, wb_data, a1, b1, c1, a0, b0, c0, busy1, busy0;
  logic [4:0] wb_rd, rd1, rd0;
  logic [8:0] oop1, oop0;
  logic [31:0][31:0] regs;
  logic [31:0] busy_m;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  decode_issue_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .instr(instr), .regs(regs),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(ov1),
    .out_ready(out_ready), .out_op(oop1), .op1(a1), .op2(b1), .op3(c1), .rd(rd1), .busy(busy1));
  decode_issue_stage #(.XLEN(32), .NUM_REGS(32), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .instr(instr), .regs(regs),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .out_valid(ov0),
    .out_ready(out_ready), .out_op(oop0), .op1(a0), .op2(b0), .op3(c0), .rd(rd0), .busy(busy0));

  function automatic logic [31:0] src(input logic [4:0] r, input logic byp);
    return r == 0 ? 32'd0 : (byp && wb_valid && wb_rd == r) ? wb_data : regs[r];
  endfunction
  function automatic logic stl(input logic [4:0] r, input logic byp);
    return r != 0 && busy_m[r] && !(byp && wb_valid && wb_rd == r);
  endfunction
  function automatic void model(input logic [31:0] i, input logic byp, output logic [8:0] op,
                                output logic [31:0] e1, output logic [31:0] e2, output logic [31:0] e3,
                                output logic [4:0] erd, output logic hz);
    logic [4:0] s1 = i[19:15];
    logic [4:0] s2 = i[24:20];
    logic [31:0] imm_i = {{20{i[31]}}, i[31:20]};
    logic [31:0] imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    logic [31:0] imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [31:0] imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    op = '0; e1 = '0; e2 = '0; e3 = '0; erd = '0; hz = 1'b0;
    case (i[6:0])
      7'h33: begin op = 9'h001; e1 = src(s1, byp); e2 = src(s2, byp); erd = i[11:7]; hz = stl(s1, byp) || stl(s2, byp); end
      7'h13, 7'h03, 7'h67: begin
        op = i[6:0] == 7'h13 ? 9'h002 : i[6:0] == 7'h03 ? 9'h004 : 9'h008;
        e1 = src(s1, byp);
        e2 = (i[6:0] == 7'h13 && i[13:12] == 2'b01) ? {27'b0, s2} : imm_i;
        erd = i[11:7]; hz = stl(s1, byp);
      end
      7'h23, 7'h63: begin
        op = i[6:0] == 7'h23 ? 9'h010 : 9'h020;
        e1 = src(s1, byp); e2 = src(s2, byp); e3 = i[6:0] == 7'h23 ? imm_s : imm_b;
        hz = stl(s1, byp) || stl(s2, byp);
      end
      7'h6f: begin op = 9'h040; e1 = imm_j; erd = i[11:7]; end
      7'h37, 7'h17: begin op = i[6:0] == 7'h37 ? 9'h080 : 9'h100; e1 = {i[31:12], 12'b0}; erd = i[11:7]; end
      default: ;
    endcase
  endfunction
  function automatic logic [31:0] add_ins(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'd0, s2, s1, 3'd0, d, 7'h33};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; iv1 = 1'b0; iv0 = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1; instr = '0; busy_m = '0;
    for (int i = 0; i < 32; i++) regs[i] = i;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests++;
    if ({ov1, oop1, a1, b1, c1, rd1, busy1} !== '0)
      $display("FAIL reset_state: got ov=%b op=%h op1=%h op2=%h op3=%h rd=%0d busy=%h expected all zero", ov1, oop1, a1, b1, c1, rd1, busy1);
    do_reset();
  endtask

  task automatic test_opcodes();
    logic [6:0] opcs[11] = '{7'h33, 7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6f, 7'h37, 7'h17, 7'h7f};
    logic [8:0] eop; logic [31:0] e1, e2, e3, base; logic [4:0] erd; logic hz;
    do_reset();
    base = 32'h12345678;
    for (int k = 0; k < 11; k++) begin
      instr = base;
      instr[6:0] = opcs[k];
      instr[11:7] = 5'd5; instr[19:15] = 5'd1; instr[24:20] = 5'd2;
      if (k == 2) instr[14:12] = 3'b000;
      iv1 = 1'b1;
      model(instr, 1'b1, eop, e1, e2, e3, erd, hz);
      #1;
      if (k == 0) begin
        tests++;
        if (ov1 !== 1'b0) begin fails++; $display("FAIL latency_pre: out_valid got %b expected 0", ov1); end
      end
      tests++;
      if (ir1 !== 1'b1) begin fails++; $display("FAIL opc_ready[%0d]: in_ready got %b expected 1", k, ir1); end
      tick();
      tests++;
      if ({ov1, oop1, a1, b1, c1, rd1} !== {1'b1, eop, e1, e2, e3, erd}) begin
        fails++;
        $display("FAIL opc_issue[%0d]: got v=%b op=%h %h %h %h rd=%0d expected v=1 op=%h %h %h %h rd=%0d",
                 k, ov1, oop1, a1, b1, c1, rd1, eop, e1, e2, e3, erd);
      end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_stall_bypass();
    do_reset();
    iv1 = 1'b1; iv0 = 1'b1; instr = add_ins(5, 1, 2);
    tick();
    instr = add_ins(6, 5, 3);
    #1;
    tests++;
    if ({ir1, ir0, busy1[5], busy0[5]} !== 4'b0011) begin
      fails++; $display("FAIL raw_stall: got ir1=%b ir0=%b busy1[5]=%b busy0[5]=%b expected 0 0 1 1", ir1, ir0, busy1[5], busy0[5]);
    end
    tick();
    tests++;
    if (ir1 !== 1'b0) begin fails++; $display("FAIL raw_stall_hold: in_ready got %b expected 0", ir1); end
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE;
    #1;
    tests++;
    if ({ir1, ir0} !== 2'b10) begin fails++; $display("FAIL bypass_ready: got ir1=%b ir0=%b expected 1 0", ir1, ir0); end
    tick();
    regs[5] = 32'hCAFE;
    iv1 = 1'b0; wb_valid = 1'b0;
    #1;
    tests++;
    if ({ov1, a1, b1, rd1, busy1[6:5]} !== {1'b1, 32'hCAFE, 32'd3, 5'd6, 2'b10}) begin
      fails++; $display("FAIL bypass_issue: got v=%b op1=%h op2=%h rd=%0d busy[6:5]=%b expected 1 cafe 3 6 10", ov1, a1, b1, rd1, busy1[6:5]);
    end
    tests++;
    if ({ir0, ov0, busy0[5]} !== 3'b100) begin
      fails++; $display("FAIL nobypass_wait: got ir0=%b ov0=%b busy0[5]=%b expected 1 0 0", ir0, ov0, busy0[5]);
    end
    tick();
    iv0 = 1'b0;
    tests++;
    if ({ov0, a0, rd0} !== {1'b1, 32'hCAFE, 5'd6}) begin
      fails++; $display("FAIL nobypass_issue: got v=%b op1=%h rd=%0d expected 1 cafe 6", ov0, a0, rd0);
    end
  endtask

  task automatic test_hold();
    do_reset();
    iv1 = 1'b1; out_ready = 1'b0; instr = add_ins(5, 1, 2);
    tick();
    instr = {12'd9, 5'd3, 3'd0, 5'd7, 7'h13};
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if ({ir1, ov1, oop1, a1, b1, c1, rd1} !== {1'b0, 1'b1, 9'h001, 32'd1, 32'd2, 32'd0, 5'd5}) begin
        fails++; $display("FAIL hold[%0d]: got ir=%b v=%b op=%h %h %h %h rd=%0d expected 0 1 001 1 2 0 5", c, ir1, ov1, oop1, a1, b1, c1, rd1);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (ir1 !== 1'b1) begin fails++; $display("FAIL hold_release: in_ready got %b expected 1", ir1); end
    tick();
    iv1 = 1'b0;
    tests++;
    if ({ov1, a1, b1, rd1} !== {1'b1, 32'd3, 32'd9, 5'd7}) begin
      fails++; $display("FAIL hold_next: got v=%b op1=%h op2=%h rd=%0d expected 1 3 9 7", ov1, a1, b1, rd1);
    end
  endtask

  task automatic test_x0();
    do_reset();
    iv1 = 1'b1; instr = {12'd1, 5'd7, 3'd0, 5'd0, 7'h13};
    #1;
    tests++;
    if (ir1 !== 1'b1) begin fails++; $display("FAIL x0_ready1: in_ready got %b expected 1", ir1); end
    tick();
    tests++;
    if ({busy1, rd1, a1, b1} !== {32'd0, 5'd0, 32'd7, 32'd1}) begin
      fails++; $display("FAIL x0_addi: got busy=%h rd=%0d op1=%h op2=%h expected 0 0 7 1", busy1, rd1, a1, b1);
    end
    instr = {7'd0, 5'd0, 5'd7, 3'b010, 5'd4, 7'h23};
    #1;
    tests++;
    if (ir1 !== 1'b1) begin fails++; $display("FAIL x0_ready2: in_ready got %b expected 1", ir1); end
    tick();
    iv1 = 1'b0;
    tests++;
    if ({busy1, rd1, a1, b1, c1} !== {32'd0, 5'd0, 32'd7, 32'd0, 32'd4}) begin
      fails++; $display("FAIL x0_sw: got busy=%h rd=%0d op1=%h op2=%h op3=%h expected 0 0 7 0 4", busy1, rd1, a1, b1, c1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; iv1 = 1'b1; instr = add_ins(9, 1, 2);
    tick();
    iv1 = 1'b0;
    tests++;
    if ({ov1, busy1[9]} !== 2'b11) begin fails++; $display("FAIL flush_pre: got v=%b busy[9]=%b expected 1 1", ov1, busy1[9]); end
    flush = 1'b1;
    #1;
    tests++;
    if (ir1 !== 1'b0) begin fails++; $display("FAIL flush_ready: in_ready got %b expected 0", ir1); end
    tick();
    flush = 1'b0;
    tests++;
    if ({ov1, busy1[9]} !== 2'b00) begin fails++; $display("FAIL flush_post: got v=%b busy[9]=%b expected 0 0", ov1, busy1[9]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    iv1 = 1'b1; instr = add_ins(5, 1, 2);
    tick();
    instr = add_ins(9, 1, 2);
    tick();
    iv1 = 1'b0; out_ready = 1'b0;
    tests++;
    if ({ov1, busy1} !== {1'b1, 32'h0000_0220}) begin fails++; $display("FAIL rstmid_pre: got v=%b busy=%h expected 1 00000220", ov1, busy1); end
    rst = 1'b1;
    #1;
    tests++;
    if ({ov1, busy1} !== 33'd0) begin fails++; $display("FAIL rstmid_async: got v=%b busy=%h expected 0 0", ov1, busy1); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] eop, hop; logic [31:0] e1, e2, e3, h1, h2, h3, nb; logic [4:0] erd, hrd; logic hz, er, fire, hv;
    do_reset();
    hv = 1'b0; hop = '0; h1 = '0; h2 = '0; h3 = '0; hrd = '0;
    for (int n = 0; n < 500; n++) begin
      instr = $urandom;
      case ($urandom % 10)
        0: instr[6:0] = 7'h33; 1: instr[6:0] = 7'h13; 2: instr[6:0] = 7'h03; 3: instr[6:0] = 7'h67;
        4: instr[6:0] = 7'h23; 5: instr[6:0] = 7'h63; 6: instr[6:0] = 7'h6f; 7: instr[6:0] = 7'h37;
        8: instr[6:0] = 7'h17; default: instr[6:0] = 7'h7f;
      endcase
      instr[11:7] = 5'($urandom % 8); instr[19:15] = 5'($urandom % 8); instr[24:20] = 5'($urandom % 8);
      iv1 = ($urandom % 4) != 0; out_ready = ($urandom % 4) != 0; flush = ($urandom % 16) == 0;
      wb_valid = ($urandom % 3) == 0; wb_rd = 5'($urandom % 8); wb_data = $urandom;
      #1;
      model(instr, 1'b1, eop, e1, e2, e3, erd, hz);
      er = !hz && (!hv || out_ready) && !flush;
      tests++;
      if (ir1 !== er) begin fails++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, ir1, er); end
      fire = iv1 && er;
      nb = busy_m;
      if (flush && hv) nb[hrd] = 1'b0;
      if (wb_valid) nb[wb_rd] = 1'b0;
      if (fire) nb[erd] = 1'b1;
      nb[0] = 1'b0;
      tick();
      if (wb_valid && wb_rd != 0) regs[wb_rd] = wb_data;
      busy_m = nb;
      if (fire) begin hop = eop; h1 = e1; h2 = e2; h3 = e3; hrd = erd; end
      hv = !flush && (fire || (hv && !out_ready));
      tests++;
      if ({ov1, oop1, a1, b1, c1, rd1, busy1} !== {hv, hop, h1, h2, h3, hrd, busy_m}) begin
        fails++;
        $display("FAIL rnd_out[%0d]: got v=%b op=%h %h %h %h rd=%0d busy=%h expected v=%b op=%h %h %h %h rd=%0d busy=%h",
                 n, ov1, oop1, a1, b1, c1, rd1, busy1, hv, hop, h1, h2, h3, hrd, busy_m);
      end
    end
    iv1 = 1'b0; wb_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iv1 = 1'b0; iv0 = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1; instr = '0; busy_m = '0;
    for (int i = 0; i < 32; i++) regs[i] = i;
    test_reset();
    test_opcodes();
    test_stall_bypass();
    test_hold();
    test_x0();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
